reg_word_serializer: RTL and testbench

- Read-side counterpart to the 32-bit enable-load register: takes a parallel word from a register output and transmits it bit-serially on a single line.
- Typical use: shipping register contents (score, board row, debug words) to an off-chip debug/UART port or a serial peripheral.
- Framed, LSB-first transmission: start bit, WIDTH data bits, stop bit.
- Uses a ready/load handshake so the sourcing register knows when it may change.

---
 rtl/tetris_pkg.sv | 19 +
 rtl/reg_word_serializer_bit_timer.sv | 42 ++++
 rtl/reg_word_serializer.sv | 105 ++++++++++
 tb/tb_reg_word_serializer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared types and constants for the register word serializer.
// Holds the FSM state encoding, default word size and a width helper.
package tetris_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int unsigned WORD_W = 32;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_word_serializer_bit_timer.sv
// Bit-period divider: counts 0..DIV-1 while active.
// Flags the first and last cycle of each serial bit.
module bit_timer
  import tetris_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic restart_i,
  input  logic active_i,
  output logic end_o,
  output logic strobe_o
);

  localparam int unsigned CW = cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign end_o    = active_i && (cnt_q == LAST);
  assign strobe_o = active_i && (cnt_q == '0);

  // Next count: wrap at the end of a bit, hold at zero when idle.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || !active_i || end_o) begin
      cnt_d = '0;
    end
  end

  // Divider register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_word_serializer.sv
// Framed LSB-first serializer for a parallel register word.
// Start bit, WIDTH data bits, stop bit; ready/load handshake.
module reg_word_serializer
  import tetris_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned DIV   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  output logic             ready,
  output logic             busy,
  output logic             sout,
  output logic             bit_strobe,
  output logic             done
);

  localparam int unsigned BW = cnt_w(WIDTH);
  localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_nx;
  logic [BW-1:0]    bcnt_q;
  logic             sout_q;
  logic             done_q;
  logic             accept;
  logic             t_end;
  logic             t_strobe;
  logic             restart;

  assign accept  = load && (state_q == IDLE);
  assign restart = (state_q == IDLE) ? accept : t_end;
  assign sh_nx   = sh_q >> 1;

  bit_timer #(
    .DIV(DIV)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .restart_i(restart),
    .active_i (state_q != IDLE),
    .end_o    (t_end),
    .strobe_o (t_strobe)
  );

  assign ready      = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign bit_strobe = t_strobe;
  assign sout       = sout_q;
  assign done       = done_q;

  // Frame FSM with shift register, bit counter and registered line/done.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bcnt_q  <= '0;
      sout_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          sout_q <= 1'b1;
          if (accept) begin
            sh_q    <= in;
            sout_q  <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (t_end) begin
            sout_q  <= sh_q[0];
            bcnt_q  <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (t_end) begin
            sh_q <= sh_nx;
            if (bcnt_q == BLAST) begin
              sout_q  <= 1'b1;
              state_q <= STOP;
            end else begin
              sout_q <= sh_nx[0];
              bcnt_q <= bcnt_q + BW'(1);
            end
          end
        end
        STOP: begin
          if (t_end) begin
            sout_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_word_serializer.sv
// Directed self-checking bench for reg_word_serializer.
// Four instances cover WIDTH/DIV corners; checks sampled on negedge.
module tb_reg_word_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: WIDTH=32, DIV=2
  logic a_rst, a_load, a_rdy, a_busy, a_sout, a_stb, a_done;
  logic [31:0] a_in;
  reg_word_serializer #(.WIDTH(32), .DIV(2)) u_a (
    .clock(clk), .reset(a_rst), .in(a_in), .load(a_load),
    .ready(a_rdy), .busy(a_busy), .sout(a_sout),
    .bit_strobe(a_stb), .done(a_done)
  );

  // B: WIDTH=32, DIV=4
  logic b_rst, b_load, b_rdy, b_busy, b_sout, b_stb, b_done;
  logic [31:0] b_in;
  reg_word_serializer #(.WIDTH(32), .DIV(4)) u_b (
    .clock(clk), .reset(b_rst), .in(b_in), .load(b_load),
    .ready(b_rdy), .busy(b_busy), .sout(b_sout),
    .bit_strobe(b_stb), .done(b_done)
  );

  // C: WIDTH=1, DIV=1
  logic c_rst, c_load, c_rdy, c_busy, c_sout, c_stb, c_done;
  logic [0:0] c_in;
  reg_word_serializer #(.WIDTH(1), .DIV(1)) u_c (
    .clock(clk), .reset(c_rst), .in(c_in), .load(c_load),
    .ready(c_rdy), .busy(c_busy), .sout(c_sout),
    .bit_strobe(c_stb), .done(c_done)
  );

  // D: WIDTH=32, DIV=3
  logic d_rst, d_load, d_rdy, d_busy, d_sout, d_stb, d_done;
  logic [31:0] d_in;
  reg_word_serializer #(.WIDTH(32), .DIV(3)) u_d (
    .clock(clk), .reset(d_rst), .in(d_in), .load(d_load),
    .ready(d_rdy), .busy(d_busy), .sout(d_sout),
    .bit_strobe(d_stb), .done(d_done)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] rec;
    logic        e;
    int          nstb;
    int          sawd;
    int          gotd;

    {a_rst, b_rst, c_rst, d_rst} = 4'hF;
    {a_load, b_load, c_load, d_load} = 4'h0;
    a_in = '0; b_in = '0; c_in = '0; d_in = '0;
    repeat (2) @(negedge clk);

    // 1. reset state and idle
    check("rst_sout", a_sout, 1);
    check("rst_ready", a_rdy, 1);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_stb", a_stb, 0);
    {a_rst, b_rst, c_rst, d_rst} = 4'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d", i),
            {a_sout, a_rdy, a_busy, a_done}, 4'b1100);
    end

    // 2. one frame, DIV=2, word A5A50F0F
    w = 32'hA5A5_0F0F;
    a_in = w;
    a_load = 1'b1;
    nstb = 0;
    for (int c = 0; c <= 68; c++) begin
      @(negedge clk);
      if (c < 2) e = 1'b0;
      else if (c < 66) e = w[(c - 2) / 2];
      else e = 1'b1;
      if (c < 68) begin
        check($sformatf("f2_sout_c%0d", c), a_sout, e);
        if (a_stb) nstb++;
      end else begin
        check("f2_done", a_done, 1);
        check("f2_ready", a_rdy, 1);
        check("f2_nstb", nstb, 34);
      end
      if (c == 0) begin
        check("f2_ready0", a_rdy, 0);
        check("f2_busy0", a_busy, 1);
        a_load = 1'b0;
      end
    end

    // 3. load held and in changed mid-frame, then reset abort
    @(negedge clk);
    a_in = 32'h0000_0001;
    a_load = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      e = (c == 2 || c == 3);
      check($sformatf("f3_sout_c%0d", c), a_sout, e);
      check($sformatf("f3_rdy_c%0d", c), a_rdy, 0);
      a_in = $urandom;
      if (c == 10) begin
        a_rst = 1'b1;
        a_load = 1'b0;
      end
    end
    @(negedge clk);
    check("f3_abort",
          {a_sout, a_rdy, a_busy, a_done}, 4'b1100);
    a_rst = 1'b0;
    sawd = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (a_done || !a_sout) sawd++;
    end
    check("f3_no_done", sawd, 0);

    // 4. back-to-back, DIV=4
    b_in = 32'hFFFF_FFFF;
    b_load = 1'b1;
    for (int c = 0; c <= 273; c++) begin
      @(negedge clk);
      if (c < 4) e = 1'b0;
      else if (c < 137) e = 1'b1;
      else if (c < 269) e = 1'b0;
      else e = 1'b1;
      check($sformatf("f4_sout_c%0d", c), b_sout, e);
      if (c == 0) b_load = 1'b0;
      if (c == 136) begin
        check("f4_done1", b_done, 1);
        check("f4_rdy1", b_rdy, 1);
        b_in = 32'h0;
        b_load = 1'b1;
      end
      if (c == 137) begin
        check("f4_busy2", b_busy, 1);
        b_load = 1'b0;
      end
      if (c == 273) check("f4_done2", b_done, 1);
    end

    // 5. WIDTH=1, DIV=1
    c_in = 1'b1;
    c_load = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      c_load = 1'b0;
      check($sformatf("f5_c%0d", c),
            {c_sout, c_stb, c_done},
            (c == 0) ? 3'b010 :
            (c == 3) ? 3'b101 : 3'b110);
    end

    // 6. 200 random frames, DIV=3, mid-bit scoreboard
    @(negedge clk);
    for (int f = 0; f < 200; f++) begin
      w = $urandom;
      d_in = w;
      d_load = 1'b1;
      rec = '0;
      for (int c = 0; c <= 101; c++) begin
        @(negedge clk);
        d_load = 1'b0;
        d_in = $urandom;
        if (c >= 4 && ((c - 4) % 3) == 0 && ((c - 4) / 3) < 32)
          rec[(c - 4) / 3] = d_sout;
      end
      gotd = 0;
      for (int k = 0; k < 5 && gotd == 0; k++) begin
        @(negedge clk);
        if (d_done) gotd = 1;
      end
      check($sformatf("f6_done%0d", f), gotd, 1);
      check($sformatf("f6_word%0d", f), rec, w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
